// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares RAM port A between the core (requester 0) and the
// loader/DMA engine (requester 1). The core has priority. After MAX_BURST
// consecutive contended core grants, the DMA is forced in for one slot.
// Requests are steered onto the RAM pins combinationally in the grant cycle.
// Read data is returned one cycle later to the requester that issued the read.
// Accesses outside the RAM window set a sticky err_oob flag, suppress writes
// and read back as zero.
// Optional build macro: ARB_PERF_CNT_EN adds a saturating core-stall counter
// on perf_core_stall. Without it, perf_core_stall is tied to zero.
module ram_port_arbiter #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 16,
  parameter int REQ_ADDR_W = 24,
  parameter int MAX_BURST  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [REQ_ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0]     core_wdata,
  output logic                  core_gnt,
  output logic                  core_rvalid,
  output logic [DATA_W-1:0]     core_rdata,
  input  logic                  dma_req,
  input  logic                  dma_we,
  input  logic [REQ_ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0]     dma_wdata,
  output logic                  dma_gnt,
  output logic                  dma_rvalid,
  output logic [DATA_W-1:0]     dma_rdata,
  output logic                  ram_we,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W-1:0]     ram_din,
  input  logic [DATA_W-1:0]     ram_dout,
  output logic                  err_oob,
  output logic [15:0]           perf_core_stall
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CORE = 2'd1,
    S_DMA  = 2'd2
  } state_t;

  localparam logic [7:0] BURST_LIM = 8'(MAX_BURST);

  // Owner of the previous cycle's grant. It also tags which requester gets a
  // pending read.
  state_t state_q, state_d;
  // Run length of consecutive contended core grants.
  logic [7:0] cnt_q, cnt_d;

  logic                  any_gnt;
  logic                  sel_we;
  logic [REQ_ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0]     sel_wdata;
  logic                  sel_oob;

  // Last address/data driven onto the RAM. They are held while nobody owns
  // the port.
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;

  // One read may be in flight. Its owner is state_q.
  logic rd_pend_q, rd_pend_d;
  logic rd_oob_q, rd_oob_d;
  logic err_q, err_d;

  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] core_rdata_q, core_rdata_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;

  // Grant decision and next owner/run-length. Grants are masked while reset
  // is asserted so every output is quiet during reset.
  always_comb begin
    state_d  = S_IDLE;
    cnt_d    = '0;
    core_gnt = 1'b0;
    dma_gnt  = 1'b0;
    if (rst_n) begin
      if (core_req && dma_req) begin
        if (cnt_q < BURST_LIM) begin
          core_gnt = 1'b1;
          state_d  = S_CORE;
          cnt_d    = cnt_q + 8'd1;
        end else begin
          dma_gnt = 1'b1;
          state_d = S_DMA;
        end
      end else if (core_req) begin
        core_gnt = 1'b1;
        state_d  = S_CORE;
      end else if (dma_req) begin
        dma_gnt = 1'b1;
        state_d = S_DMA;
      end
    end
  end

  // Steer the granted requester's command onto the RAM side.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (core_gnt) begin
      sel_we    = core_we;
      sel_addr  = core_addr;
      sel_wdata = core_wdata;
    end else if (dma_gnt) begin
      sel_we    = dma_we;
      sel_addr  = dma_addr;
      sel_wdata = dma_wdata;
    end
  end

  assign any_gnt = core_gnt | dma_gnt;
  assign sel_oob = any_gnt && (sel_addr[REQ_ADDR_W-1:ADDR_W] != '0);

  assign ram_we   = any_gnt & sel_we & ~sel_oob;
  assign ram_addr = any_gnt ? sel_addr[ADDR_W-1:0] : addr_q;
  assign ram_din  = any_gnt ? sel_wdata : din_q;

  // Read return. Data arrives from the RAM one cycle after the grant.
  // Out-of-range reads are forced to zero.
  assign core_rvalid = rd_pend_q && (state_q == S_CORE);
  assign dma_rvalid  = rd_pend_q && (state_q == S_DMA);
  assign rd_word     = rd_oob_q ? '0 : ram_dout;
  assign core_rdata  = core_rvalid ? rd_word : core_rdata_q;
  assign dma_rdata   = dma_rvalid ? rd_word : dma_rdata_q;
  assign err_oob     = err_q;

  // Next-state for the datapath side registers.
  always_comb begin
    addr_d       = addr_q;
    din_d        = din_q;
    rd_pend_d    = any_gnt & ~sel_we;
    rd_oob_d     = sel_oob;
    err_d        = err_q | sel_oob;
    core_rdata_d = core_rdata;
    dma_rdata_d  = dma_rdata;
    if (any_gnt) begin
      addr_d = sel_addr[ADDR_W-1:0];
      din_d  = sel_wdata;
    end
  end

  // Owner/run-length state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Held RAM command, in-flight read tracking, sticky error and read holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q       <= '0;
      din_q        <= '0;
      rd_pend_q    <= 1'b0;
      rd_oob_q     <= 1'b0;
      err_q        <= 1'b0;
      core_rdata_q <= '0;
      dma_rdata_q  <= '0;
    end else begin
      addr_q       <= addr_d;
      din_q        <= din_d;
      rd_pend_q    <= rd_pend_d;
      rd_oob_q     <= rd_oob_d;
      err_q        <= err_d;
      core_rdata_q <= core_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (core_req && !core_gnt && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  // Saturating count of cycles the core waited on the port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign perf_core_stall = stall_q;
`else
  assign perf_core_stall = 16'h0000;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Testbench for ram_port_arbiter. It runs directed scenarios, then randomized
// two-requester traffic, against a transaction-level reference model.
module tb_ram_port_arbiter;
  localparam int ADDR_W     = 15;
  localparam int DATA_W     = 16;
  localparam int REQ_ADDR_W = 24;
  localparam int MAX_BURST  = 8;
  localparam int DEPTH      = 1 << ADDR_W;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  core_req = 1'b0, core_we = 1'b0;
  logic [REQ_ADDR_W-1:0] core_addr = '0;
  logic [DATA_W-1:0]     core_wdata = '0;
  logic                  core_gnt, core_rvalid;
  logic [DATA_W-1:0]     core_rdata;
  logic                  dma_req = 1'b0, dma_we = 1'b0;
  logic [REQ_ADDR_W-1:0] dma_addr = '0;
  logic [DATA_W-1:0]     dma_wdata = '0;
  logic                  dma_gnt, dma_rvalid;
  logic [DATA_W-1:0]     dma_rdata;
  logic                  ram_we;
  logic [ADDR_W-1:0]     ram_addr;
  logic [DATA_W-1:0]     ram_din;
  logic [DATA_W-1:0]     ram_dout = '0;
  logic                  err_oob;
  logic [15:0]           perf_core_stall;

  always #5 clk = ~clk;

  ram_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .REQ_ADDR_W(REQ_ADDR_W), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .err_oob(err_oob), .perf_core_stall(perf_core_stall)
  );

  function automatic logic [DATA_W-1:0] init_word(input logic [ADDR_W-1:0] a);
    return (16'(a) * 16'd13) ^ 16'h5A5A;
  endfunction

  // Synchronous-read RAM behind port A (read-first). Unwritten words hold a
  // known pattern.
  bit [DATA_W-1:0] ram_mem [DEPTH];
  bit              ram_wr  [DEPTH];
  always @(posedge clk) begin
    ram_dout <= ram_wr[ram_addr] ? ram_mem[ram_addr] : init_word(ram_addr);
    if (ram_we) begin
      ram_mem[ram_addr] <= ram_din;
      ram_wr[ram_addr]  <= 1'b1;
    end
  end

  // Reference model state.
  logic [DATA_W-1:0] exp_mem [DEPTH];
  int                core_run;
  bit                err_exp;
  int                stall_exp;
  bit                pend_v, pend_dma;
  logic [DATA_W-1:0] pend_data;
  logic [DATA_W-1:0] core_rdata_exp, dma_rdata_exp;
  logic [ADDR_W-1:0] last_addr;
  logic [DATA_W-1:0] last_din;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    core_run       = 0;
    err_exp        = 1'b0;
    stall_exp      = 0;
    pend_v         = 1'b0;
    pend_dma       = 1'b0;
    pend_data      = '0;
    core_rdata_exp = '0;
    dma_rdata_exp  = '0;
    last_addr      = '0;
    last_din       = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_core_gnt"},    32'(core_gnt), 0);
    check({tag, "_dma_gnt"},     32'(dma_gnt), 0);
    check({tag, "_core_rvalid"}, 32'(core_rvalid), 0);
    check({tag, "_dma_rvalid"},  32'(dma_rvalid), 0);
    check({tag, "_core_rdata"},  32'(core_rdata), 0);
    check({tag, "_dma_rdata"},   32'(dma_rdata), 0);
    check({tag, "_ram_we"},      32'(ram_we), 0);
    check({tag, "_ram_addr"},    32'(ram_addr), 0);
    check({tag, "_ram_din"},     32'(ram_din), 0);
    check({tag, "_err_oob"},     32'(err_oob), 0);
    check({tag, "_perf"},        32'(perf_core_stall), 0);
  endtask

  // Drive one cycle of requests, check every output against the model and
  // advance the model. Reports which requester the model granted.
  task automatic step(input logic cr, input logic cw, input logic [REQ_ADDR_W-1:0] ca,
                      input logic [DATA_W-1:0] cd, input logic dr, input logic dw,
                      input logic [REQ_ADDR_W-1:0] da, input logic [DATA_W-1:0] dd,
                      output logic cg, output logic dg);
    bit                    own_c, own_d, any, we, oob;
    logic [REQ_ADDR_W-1:0] a;
    logic [DATA_W-1:0]     d;
    @(negedge clk);
    core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
    dma_req  = dr; dma_we  = dw; dma_addr  = da; dma_wdata  = dd;
    #1;
    own_c = 1'b0;
    own_d = 1'b0;
    if (cr && dr) begin
      if (core_run >= MAX_BURST) own_d = 1'b1;
      else own_c = 1'b1;
    end else if (cr) begin
      own_c = 1'b1;
    end else if (dr) begin
      own_d = 1'b1;
    end
    any = own_c | own_d;
    we  = own_c ? cw : dw;
    a   = own_c ? ca : da;
    d   = own_c ? cd : dd;
    oob = any && (a[REQ_ADDR_W-1:ADDR_W] != '0);
    if (any) begin
      last_addr = a[ADDR_W-1:0];
      last_din  = d;
    end
    check("core_gnt", 32'(core_gnt), 32'(own_c));
    check("dma_gnt",  32'(dma_gnt),  32'(own_d));
    check("ram_we",   32'(ram_we),   32'(any && we && !oob));
    check("ram_addr", 32'(ram_addr), 32'(last_addr));
    check("ram_din",  32'(ram_din),  32'(last_din));
    if (pend_v) begin
      if (pend_dma) dma_rdata_exp = pend_data;
      else core_rdata_exp = pend_data;
    end
    check("core_rvalid", 32'(core_rvalid), 32'(pend_v && !pend_dma));
    check("dma_rvalid",  32'(dma_rvalid),  32'(pend_v && pend_dma));
    check("core_rdata",  32'(core_rdata),  32'(core_rdata_exp));
    check("dma_rdata",   32'(dma_rdata),   32'(dma_rdata_exp));
    check("err_oob",     32'(err_oob),     32'(err_exp));
`ifdef ARB_PERF_CNT_EN
    check("perf_core_stall", 32'(perf_core_stall), 32'(stall_exp));
`else
    check("perf_core_stall", 32'(perf_core_stall), 0);
`endif
    pend_v    = any && !we;
    pend_dma  = own_d;
    pend_data = oob ? '0 : exp_mem[a[ADDR_W-1:0]];
    if (any && we && !oob) exp_mem[a[ADDR_W-1:0]] = d;
    if (oob) err_exp = 1'b1;
    core_run = (own_c && dr) ? core_run + 1 : 0;
    if (cr && !own_c && stall_exp < 65535) stall_exp++;
    cg = own_c;
    dg = own_d;
  endtask

  task automatic idle(output logic cg, output logic dg);
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, cg, dg);
  endtask

  function automatic logic [REQ_ADDR_W-1:0] rand_addr(input bit oob_en);
    logic [REQ_ADDR_W-1:0] a;
    a = REQ_ADDR_W'($urandom_range(0, 63));
    if (oob_en && $urandom_range(0, 15) == 0)
      a[REQ_ADDR_W-1:ADDR_W] = 9'($urandom_range(1, 511));
    return a;
  endfunction

  // Randomized traffic. Each requester holds its command until granted and
  // occasionally withdraws it.
  task automatic run_random(input int n, input bit oob_en);
    logic cr, cw, dr, dw, cg, dg;
    logic [REQ_ADDR_W-1:0] ca, da;
    logic [DATA_W-1:0] cd, dd;
    cr = 1'b0; cw = 1'b0; ca = '0; cd = '0;
    dr = 1'b0; dw = 1'b0; da = '0; dd = '0;
    for (int i = 0; i < n; i++) begin
      if (!cr) begin
        if ($urandom_range(0, 3) != 0) begin
          cr = 1'b1; cw = 1'($urandom_range(0, 1)); ca = rand_addr(oob_en); cd = 16'($urandom);
        end
      end else if ($urandom_range(0, 15) == 0) begin
        cr = 1'b0;
      end
      if (!dr) begin
        if ($urandom_range(0, 2) != 0) begin
          dr = 1'b1; dw = 1'($urandom_range(0, 1)); da = rand_addr(oob_en); dd = 16'($urandom);
        end
      end else if ($urandom_range(0, 15) == 0) begin
        dr = 1'b0;
      end
      step(cr, cw, ca, cd, dr, dw, da, dd, cg, dg);
      if (cg) cr = 1'b0;
      if (dg) dr = 1'b0;
    end
    idle(cg, dg);
  endtask

  initial begin
    logic cg, dg;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = init_word(ADDR_W'(i));
    model_reset();

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("rst0");
    @(negedge clk);
    rst_n = 1'b1;

    // DMA writes BEEF at 0x10, then a core read returns it a cycle later.
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 24'h000010, 16'hBEEF, cg, dg);
    step(1'b1, 1'b0, 24'h000010, '0, 1'b0, 1'b0, '0, '0, cg, dg);
    check("t1_gnt", 32'(cg), 1);
    check("t1_ram_addr", 32'(ram_addr), 32'h0010);
    idle(cg, dg);
    check("t1_rdata", 32'(core_rdata), 32'hBEEF);
    check("t1_dma_rvalid", 32'(dma_rvalid), 0);

    // Core write 0x1234 at 0x20, then an immediate read of the same word.
    step(1'b1, 1'b1, 24'h000020, 16'h1234, 1'b0, 1'b0, '0, '0, cg, dg);
    check("t2_ram_we", 32'(ram_we), 1);
    step(1'b1, 1'b0, 24'h000020, '0, 1'b0, 1'b0, '0, '0, cg, dg);
    check("t2_ram_we_rd", 32'(ram_we), 0);
    idle(cg, dg);
    check("t2_rdata", 32'(core_rdata), 32'h1234);

    // Continuous contention: 8 core grants, 1 DMA grant, repeating.
    for (int i = 0; i < 27; i++) begin
      step(1'b1, 1'b0, 24'h000100 + 24'(i), '0, 1'b1, 1'b0, 24'h000200 + 24'(i / 9), '0, cg, dg);
      check("t3_core_slot", 32'(cg), 32'((i % 9) != 8));
      check("t3_dma_slot",  32'(dg), 32'((i % 9) == 8));
      if (i == 8) begin
        idle(cg, dg);
        check("t3_dma_rvalid", 32'(dma_rvalid), 1);
`ifdef ARB_PERF_CNT_EN
        check("t3_perf_window", 32'(perf_core_stall), 1);
`else
        check("t3_perf_window", 32'(perf_core_stall), 0);
`endif
      end
    end
    idle(cg, dg);

    run_random(300, 1'b0);

    // Reset in the cycle after a core read grant drops the pending read.
    step(1'b1, 1'b0, 24'h000030, '0, 1'b0, 1'b0, '0, '0, cg, dg);
    @(negedge clk);
    core_req = 1'b0;
    dma_req  = 1'b0;
    rst_n    = 1'b0;
    #1;
    check_all_zero("rst1");
    @(negedge clk);
    #1;
    check_all_zero("rst1_hold");
    rst_n = 1'b1;
    model_reset();
    idle(cg, dg);
    check("t5_no_rvalid", 32'(core_rvalid), 0);

    // Out-of-range DMA write, then a read of the same out-of-range address.
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 24'h010000, 16'hCAFE, cg, dg);
    check("t4_gnt", 32'(dg), 1);
    check("t4_ram_we", 32'(ram_we), 0);
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 24'h010000, '0, cg, dg);
    check("t4_err_set", 32'(err_oob), 1);
    idle(cg, dg);
    check("t4_rvalid", 32'(dma_rvalid), 1);
    check("t4_rdata", 32'(dma_rdata), 0);
    idle(cg, dg);
    check("t4_err_sticky", 32'(err_oob), 1);

    run_random(400, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
